// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch predictor: resolver kind encodings and
// saturating-counter helpers used by the pattern history table.
package branch_predictor_btb_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'b00,
    KIND_JUMP = 2'b01,
    KIND_JREG = 2'b10,
    KIND_RSVD = 2'b11
  } upd_kind_t;

  // Counters are at most 4 bits wide, so the helpers work on a 4-bit carrier.
  function automatic logic [3:0] ctr_reset_value(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic logic [3:0] ctr_step(input logic [3:0] ctr, input logic up,
                                          input int ctr_bits);
    logic [3:0] max_val;
    max_val = 4'((1 << ctr_bits) - 1);
    if (up) begin
      return (ctr == max_val) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, resolver training and statistics signals of the predictor.
// The pipeline side is the master, the predictor is the slave.
interface branch_predictor_btb_if #(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   lookup_pc;
  logic                  pred_taken;
  logic [PC_WIDTH-1:0]   pred_target;

  logic                  upd_valid;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic [1:0]            upd_kind;
  logic                  upd_taken;
  logic [PC_WIDTH-1:0]   upd_target;
  logic                  upd_pred_taken;
  logic [PC_WIDTH-1:0]   upd_pred_target;
  logic                  mispredict;

  logic                  stat_clear;
  logic [STAT_WIDTH-1:0] stat_branches;
  logic [STAT_WIDTH-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, stat_clear,
    input  pred_taken, pred_target, mispredict, stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, stat_clear,
    output pred_taken, pred_target, mispredict, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter_table.sv
// Pattern history table: saturating counters with one combinational read port
// (returns the counter MSB) and one read-modify-write training port.
module sat_counter_table
  import branch_predictor_btb_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_msb,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_up
);

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_value(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_next;

  assign rd_msb   = ctr_reg[rd_idx][CTR_BITS-1];
  assign ctr_next = CTR_BITS'(ctr_step(4'(ctr_reg[upd_idx]), upd_up, CTR_BITS));

  // Every counter restarts weakly not-taken so a reset discards all training.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_reg[i] <= CTR_INIT;
      end
    end else if (upd_en) begin
      ctr_reg[upd_idx] <= ctr_next;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: direct-mapped tagged BTB plus a saturating-counter
// PHT (bimodal or gshare), combinational lookup and synchronous training.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int ENTRIES    = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 0,
  parameter int STAT_WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  branch_predictor_btb_if.slave bus
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0]   btb_valid_reg;
  logic [ENTRIES-1:0]   btb_jump_reg;
  logic [TAG_WIDTH-1:0] btb_tag_reg    [ENTRIES];
  logic [PC_WIDTH-1:0]  btb_target_reg [ENTRIES];

  logic [STAT_WIDTH-1:0] stat_branches_reg;
  logic [STAT_WIDTH-1:0] stat_mispredicts_reg;

  upd_kind_t             kind;
  logic [INDEX_BITS-1:0] hist_mix;
  logic [INDEX_BITS-1:0] look_idx;
  logic [INDEX_BITS-1:0] look_pht_idx;
  logic [TAG_WIDTH-1:0]  look_tag;
  logic                  look_hit;
  logic                  look_pht_taken;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [INDEX_BITS-1:0] upd_pht_idx;
  logic [TAG_WIDTH-1:0]  upd_tag;
  logic                  upd_hit;
  logic                  eff_taken;
  logic                  btb_write;
  logic                  btb_kill;
  logic                  pht_train;
  logic                  unused_upd_pc;

  assign kind          = upd_kind_t'(bus.upd_kind);
  assign unused_upd_pc = ^bus.upd_pc;

  // History only exists in the gshare build; both ports see the pre-edge value.
  if (HIST_BITS == 0) begin : g_bimodal
    assign hist_mix = '0;
  end else begin : g_gshare
    logic [HIST_BITS-1:0] ghr_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ghr_reg <= '0;
      end else if (bus.upd_valid && kind == KIND_COND) begin
        ghr_reg <= HIST_BITS'({ghr_reg, bus.upd_taken});
      end
    end

    assign hist_mix = INDEX_BITS'(ghr_reg);
  end

  // Lookup side: zero latency so fetch can redirect in the same cycle.
  assign look_idx     = bus.lookup_pc[INDEX_BITS+1:2];
  assign look_tag     = bus.lookup_pc[INDEX_BITS+2 +: TAG_WIDTH];
  assign look_pht_idx = look_idx ^ hist_mix;
  assign look_hit     = btb_valid_reg[look_idx] && (btb_tag_reg[look_idx] == look_tag);

  assign bus.pred_taken  = look_hit && (btb_jump_reg[look_idx] || look_pht_taken);
  assign bus.pred_target = bus.pred_taken ? btb_target_reg[look_idx]
                                          : bus.lookup_pc + PC_WIDTH'(4);

  // Training side.
  assign upd_idx     = bus.upd_pc[INDEX_BITS+1:2];
  assign upd_tag     = bus.upd_pc[INDEX_BITS+2 +: TAG_WIDTH];
  assign upd_pht_idx = upd_idx ^ hist_mix;
  assign upd_hit     = btb_valid_reg[upd_idx] && (btb_tag_reg[upd_idx] == upd_tag);
  assign eff_taken   = (kind == KIND_COND) ? bus.upd_taken : 1'b1;

  assign bus.mispredict = bus.upd_valid &&
                          ((bus.upd_pred_taken != eff_taken) ||
                           (eff_taken && (bus.upd_pred_target != bus.upd_target)));

  assign btb_write = bus.upd_valid &&
                     ((kind == KIND_COND && bus.upd_taken) || kind == KIND_JUMP);
  // Register jumps never allocate; a hit is dropped so it stops redirecting.
  assign btb_kill  = bus.upd_valid && kind == KIND_JREG && upd_hit;
  assign pht_train = bus.upd_valid && kind == KIND_COND;

  sat_counter_table #(
    .ENTRIES (ENTRIES),
    .CTR_BITS(CTR_BITS)
  ) u_pht (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (look_pht_idx),
    .rd_msb (look_pht_taken),
    .upd_en (pht_train),
    .upd_idx(upd_pht_idx),
    .upd_up (bus.upd_taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid_reg <= '0;
    end else if (btb_write) begin
      btb_valid_reg[upd_idx] <= 1'b1;
    end else if (btb_kill) begin
      btb_valid_reg[upd_idx] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (btb_write) begin
      btb_tag_reg[upd_idx]    <= upd_tag;
      btb_jump_reg[upd_idx]   <= (kind == KIND_JUMP);
      btb_target_reg[upd_idx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else if (bus.stat_clear) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else if (bus.upd_valid) begin
      if (stat_branches_reg != STAT_MAX) begin
        stat_branches_reg <= stat_branches_reg + STAT_WIDTH'(1);
      end
      if (bus.mispredict && stat_mispredicts_reg != STAT_MAX) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + STAT_WIDTH'(1);
      end
    end
  end

  assign bus.stat_branches    = stat_branches_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline: a direct-mapped, tagged branch target buffer (BTB) plus a saturating-counter pattern history table (PHT), with optional gshare history.
- Looked up combinationally with the IF-stage PC so fetch can redirect in the same cycle.
- Trained synchronously by the ID-stage branch/jump resolver; replaces static "predict not-taken plus flush" fetch.
- Counts resolved branches and mispredicts for performance readout over the data-memory bus.

Parameters:
- PC_WIDTH, 32, width of PC and target addresses.
- ENTRIES, 64, BTB and PHT depth; power of two, ≥4. INDEX_BITS = log2(ENTRIES).
- TAG_WIDTH, 8, stored tag bits; INDEX_BITS+2+TAG_WIDTH ≤ PC_WIDTH.
- CTR_BITS, 2, saturating counter width, 1..4.
- HIST_BITS, 0, global history length; 0 = bimodal, 1..INDEX_BITS = gshare.
- STAT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lookup_pc  in  PC_WIDTH  IF-stage PC.
- pred_taken  out  1  predicted redirect.
- pred_target  out  PC_WIDTH  predicted next PC; lookup_pc+4 when pred_taken=0.
- upd_valid  in  1  one resolved control instruction this cycle.
- upd_pc  in  PC_WIDTH  PC of resolved instruction.
- upd_kind  in  2  00 conditional branch, 01 direct jump (j/jal), 10 register jump (jr/jalr), 11 reserved.
- upd_taken  in  1  actual outcome; ignored for kinds 01/10, which are treated as taken.
- upd_target  in  PC_WIDTH  actual target.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  PC_WIDTH  predicted target carried with the instruction.
- mispredict  out  1  combinational; valid when upd_valid=1.
- stat_clear  in  1  synchronous clear of the statistics counters.
- stat_branches  out  STAT_WIDTH  number of updates accepted.
- stat_mispredicts  out  STAT_WIDTH  number of mispredicts.

Behaviour:
- Index and tag:
  - btb_idx = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+2+TAG_WIDTH-1 : INDEX_BITS+2].
  - pht_idx = btb_idx XOR zero-extended ghr[HIST_BITS-1:0]; pht_idx = btb_idx when HIST_BITS=0.
- BTB entry: valid, tag, kind (1 bit: 0 cond, 1 jump), target.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - pred_taken = hit && (kind==jump || PHT[pht_idx] MSB==1).
  - pred_target = hit && pred_taken ? entry target : lookup_pc+4, modulo 2^PC_WIDTH.
- Mispredict: mispredict = upd_valid && (upd_pred_taken != eff_taken || (eff_taken && upd_pred_target != upd_target)), where eff_taken = upd_taken for kind 00, else 1.
- Update, on a clk edge with upd_valid=1:
  - Kind 00:
    - PHT[pht_idx(upd_pc)] increments if taken, decrements if not, saturating at 0 and 2^CTR_BITS-1.
    - If taken, write the BTB entry (valid=1, tag, kind=cond, target).
    - If not taken, leave the BTB unchanged.
    - ghr <= {ghr[HIST_BITS-2:0], upd_taken}.
  - Kind 01: write the BTB entry (kind=jump, target). PHT and ghr untouched.
  - Kind 10: if the indexed entry hits, clear its valid bit. No allocation (register targets unpredictable).
  - Kind 11: no table/ghr change; statistics still count.
- Lookup and update at the same index in the same cycle: lookup returns the pre-update contents. No bypass.
- ghr uses the ghr value held before the edge for pht_idx of the update.
- Statistics:
  - On each upd_valid, stat_branches += 1; stat_mispredicts += mispredict.
  - Both saturate at all-ones.
  - stat_clear has priority over an increment on the same edge.
- Reset (async, immediate):
  - All BTB valid bits 0.
  - All PHT counters = weakly not-taken, 2^(CTR_BITS-1)-1 (01 for 2-bit).
  - ghr = 0; stats = 0.
  - Therefore pred_taken=0 and pred_target=lookup_pc+4 during and after reset.
- Reset mid-operation discards all training. Updates with upd_valid=0 change nothing.
- Lookup_pc bits [1:0] are ignored for indexing but included in pc+4.

Decomposition:
- Shared package cpu_pkg: upd_kind encodings (KIND_COND, KIND_JUMP, KIND_JREG, KIND_RSVD) and a function for counter reset value/saturating increment.
- One natural sub-module: sat_counter_table (PHT array with async-reset init, one read port, one read-modify-write port), parametrised by ENTRIES and CTR_BITS.

Test Plan:
- Reset then lookup_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044, stats=0.
- Update cond branch pc=0x40, taken, target=0x00000100, pred_taken=0 -> mispredict=1, stat_mispredicts=1. Next lookup 0x40 -> pred_taken=1 (counter 01->10), target 0x100.
- Same branch not-taken twice -> counter 10->01->00 and lookup 0x40 -> pred_taken=0. Four more taken updates saturate at 11; one not-taken -> 10, still predicted taken.
- Aliasing with ENTRIES=64, TAG_WIDTH=8: j at pc=0x40 target 0x200, then lookup 0x140 (same index, different tag) -> pred_taken=0. Lookup 0x40 -> taken 0x200. Update jr at 0x40 -> entry invalidated, lookup 0x40 -> not taken.
- HIST_BITS=2: alternating taken/not-taken branch at 0x80, 20 updates -> after warm-up, mispredict=0 on every update. Same sequence with HIST_BITS=0 -> mispredicts persist.
- Same-cycle lookup and update of 0x40 -> old prediction returned that cycle, new one next cycle. stat_clear together with upd_valid -> stats read 0. Assert reset mid-training -> immediate pred_taken=0.
